// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Issue/collect front end for the 6502 ALU datapath. Latches one
//            ALU micro-op, drives the ALU for two cycles (DRIVE, SAMPLE),
//            captures its outputs and returns result, updated P and a
//            writeback enable over a valid/ready response channel.
// Options  : ALU_SEQ_DECIMAL_EN - when defined, ADC/SBC forward the latched
//            D flag to alu_dec_en; otherwise alu_dec_en is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] p_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sums,
  output logic       alu_ands,
  output logic       alu_ors,
  output logic       alu_eors,
  output logic       alu_srs,
  output logic       alu_dec_en,
  output logic       alu_cin,
  input  logic [7:0] alu_result,
  input  logic       alu_of,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [7:0] rsp_p,
  output logic       rsp_wr,
  output logic       rsp_err
);

  localparam logic [3:0] c_op_adc = 4'd0;
  localparam logic [3:0] c_op_sbc = 4'd1;
  localparam logic [3:0] c_op_and = 4'd2;
  localparam logic [3:0] c_op_ora = 4'd3;
  localparam logic [3:0] c_op_eor = 4'd4;
  localparam logic [3:0] c_op_cmp = 4'd5;
  localparam logic [3:0] c_op_bit = 4'd6;
  localparam logic [3:0] c_op_asl = 4'd7;
  localparam logic [3:0] c_op_lsr = 4'd8;
  localparam logic [3:0] c_op_rol = 4'd9;
  localparam logic [3:0] c_op_ror = 4'd10;
  localparam logic [3:0] c_op_inc = 4'd11;
  localparam logic [3:0] c_op_dec = 4'd12;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_DRIVE  = 4'b0010,
    ST_SAMPLE = 4'b0100,
    ST_RESP   = 4'b1000
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] p_q, p_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic [7:0] rsp_p_q, rsp_p_d;
  logic       rsp_wr_q, rsp_wr_d;
  logic       rsp_err_q, rsp_err_d;

  logic       w_active;
  logic       w_legal;
  logic [7:0] w_result;
  logic [7:0] w_p;
  logic       w_wr;
  logic       w_err;

  assign w_active   = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign w_legal    = (op_q <= c_op_dec);
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_p      = rsp_p_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;

  // ALU operand/select mapping; everything is low outside DRIVE/SAMPLE or for illegal ops
  always_comb begin
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    alu_sums = 1'b0;
    alu_ands = 1'b0;
    alu_ors  = 1'b0;
    alu_eors = 1'b0;
    alu_srs  = 1'b0;
    if (w_active && w_legal) begin
      alu_a = a_q;
      case (op_q)
        c_op_adc: begin alu_b = b_q;   alu_cin = p_q[0]; alu_sums = 1'b1; end
        c_op_sbc: begin alu_b = ~b_q;  alu_cin = p_q[0]; alu_sums = 1'b1; end
        c_op_and: begin alu_b = b_q;   alu_ands = 1'b1; end
        c_op_ora: begin alu_b = b_q;   alu_ors  = 1'b1; end
        c_op_eor: begin alu_b = b_q;   alu_eors = 1'b1; end
        c_op_cmp: begin alu_b = ~b_q;  alu_cin = 1'b1;   alu_sums = 1'b1; end
        c_op_bit: begin alu_b = b_q;   alu_ands = 1'b1; end
        c_op_asl: begin alu_b = a_q;   alu_sums = 1'b1; end
        c_op_rol: begin alu_b = a_q;   alu_cin = p_q[0]; alu_sums = 1'b1; end
        c_op_lsr: begin alu_b = 8'h01; alu_srs  = 1'b1; end
        c_op_ror: begin alu_b = 8'h01; alu_srs  = 1'b1; end
        c_op_inc: begin alu_b = 8'h01; alu_sums = 1'b1; end
        c_op_dec: begin alu_b = 8'hFF; alu_sums = 1'b1; end
        default:  begin end
      endcase
    end
  end

  // Decimal enable follows the latched D flag only for ADC/SBC when the option is built in
`ifdef ALU_SEQ_DECIMAL_EN
  always_comb begin
    alu_dec_en = w_active && p_q[3] && ((op_q == c_op_adc) || (op_q == c_op_sbc));
  end
`else
  always_comb begin
    alu_dec_en = 1'b0;
  end
`endif

  // Response build from the ALU outputs; unlisted P bits pass through from the latched P
  always_comb begin
    w_result = 8'h00;
    w_p      = p_q;
    w_wr     = 1'b0;
    w_err    = 1'b0;
    if (!w_legal) begin
      w_err = 1'b1;
    end else begin
      // ROR shifts the old carry into bit 7; the ALU only does a logical shift
      w_result = (op_q == c_op_ror) ? {p_q[0], alu_result[6:0]} : alu_result;
      w_wr     = (op_q != c_op_cmp) && (op_q != c_op_bit);
      if (op_q == c_op_bit) begin
        w_p[1] = (alu_result == 8'h00);
        w_p[7] = b_q[7];
        w_p[6] = b_q[6];
      end else begin
        w_p[7] = w_result[7];
        w_p[1] = (w_result == 8'h00);
      end
      case (op_q)
        c_op_adc, c_op_sbc:           begin w_p[0] = alu_cout; w_p[6] = alu_of; end
        c_op_cmp, c_op_asl, c_op_rol: begin w_p[0] = alu_cout; end
        c_op_lsr, c_op_ror:           begin w_p[0] = a_q[0]; end
        default:                      begin end
      endcase
    end
  end

  // Next-state and register updates: latch in IDLE, capture response at end of SAMPLE
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    rsp_result_d = rsp_result_q;
    rsp_p_d      = rsp_p_q;
    rsp_wr_d     = rsp_wr_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          p_d     = p_in;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        rsp_result_d = w_result;
        rsp_p_d      = w_p;
        rsp_wr_d     = w_wr;
        rsp_err_d    = w_err;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'h0;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      p_q          <= 8'h00;
      rsp_result_q <= 8'h00;
      rsp_p_q      <= P_RESET;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      rsp_result_q <= rsp_result_d;
      rsp_p_q      <= rsp_p_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer: directed vector table,
//            backpressure / reset corner sequences and randomized ops checked
//            against an arithmetic 6502 reference model. Includes a
//            behavioural binary ALU answering the DUT's ALU interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b, p_in;
  logic [7:0] alu_a, alu_b;
  logic       alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
  logic       alu_dec_en, alu_cin;
  logic [7:0] alu_result;
  logic       alu_of, alu_cout;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result, rsp_p;
  logic       rsp_wr, rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.P_RESET(8'h24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .p_in(p_in),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_sums(alu_sums), .alu_ands(alu_ands), .alu_ors(alu_ors),
    .alu_eors(alu_eors), .alu_srs(alu_srs),
    .alu_dec_en(alu_dec_en), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_of(alu_of), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_p(rsp_p), .rsp_wr(rsp_wr), .rsp_err(rsp_err)
  );

  // Behavioural binary ALU answering the DUT
  logic [8:0] alu_sum;
  logic [4:0] flags;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
  assign flags   = {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs};

  always_comb begin
    alu_result = 8'h00;
    alu_cout   = 1'b0;
    alu_of     = 1'b0;
    if (alu_sums) begin
      alu_result = alu_sum[7:0];
      alu_cout   = alu_sum[8];
      alu_of     = ~(alu_a[7] ^ alu_b[7]) & (alu_a[7] ^ alu_sum[7]);
    end else if (alu_ands) alu_result = alu_a & alu_b;
    else if (alu_ors)  alu_result = alu_a | alu_b;
    else if (alu_eors) alu_result = alu_a ^ alu_b;
    else if (alu_srs) begin
      alu_result = {1'b0, alu_a[7:1]};
      alu_cout   = alu_a[0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 6502 semantics computed with plain integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] p, output logic [7:0] res, output logic [7:0] po,
                                output logic wr, output logic err);
    int s, sv;
    logic c;
    c = p[0]; po = p; res = 8'h00; wr = 1'b1; err = 1'b0;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b) + int'(c);
        sv = int'($signed(a)) + int'($signed(b)) + int'(c);
        res = s[7:0]; po[0] = (s > 255); po[6] = (sv > 127) || (sv < -128);
      end
      4'd1: begin
        s = int'(a) - int'(b) - int'(!c);
        sv = int'($signed(a)) - int'($signed(b)) - int'(!c);
        res = s[7:0]; po[0] = (s >= 0); po[6] = (sv > 127) || (sv < -128);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin s = int'(a) - int'(b); res = s[7:0]; po[0] = (a >= b); wr = 1'b0; end
      4'd6: begin res = a & b; wr = 1'b0; end
      4'd7: begin res = {a[6:0], 1'b0}; po[0] = a[7]; end
      4'd8: begin res = {1'b0, a[7:1]}; po[0] = a[0]; end
      4'd9: begin res = {a[6:0], c}; po[0] = a[7]; end
      4'd10: begin res = {c, a[7:1]}; po[0] = a[0]; end
      4'd11: res = a + 8'd1;
      4'd12: res = a - 8'd1;
      default: begin err = 1'b1; wr = 1'b0; end
    endcase
    if (!err) begin
      po[1] = (res == 8'h00);
      if (op == 4'd6) begin po[7] = b[7]; po[6] = b[6]; end
      else po[7] = res[7];
    end
  endfunction

  function automatic logic [4:0] exp_sel(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12: return 5'b10000;
      4'd2, 4'd6: return 5'b01000;
      4'd3: return 5'b00100;
      4'd4: return 5'b00010;
      4'd8, 4'd10: return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [8:0] exp_bcin(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
    case (op)
      4'd0: return {b, c};
      4'd1: return {~b, c};
      4'd5: return {~b, 1'b1};
      4'd7: return {a, 1'b0};
      4'd9: return {a, c};
      4'd8, 4'd10, 4'd11: return {8'h01, 1'b0};
      4'd12: return {8'hFF, 1'b0};
      default: return {b, 1'b0};
    endcase
  endfunction

  function automatic logic exp_dec(input logic [3:0] op, input logic [7:0] p);
`ifdef ALU_SEQ_DECIMAL_EN
    return p[3] && (op == 4'd0 || op == 4'd1);
`else
    return 1'b0 & p[3] & op[0];
`endif
  endfunction

  // One complete transaction with cycle-accurate checks; the response is held for 'hold'
  // extra cycles while a stray request is presented, and released together with req_valid.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] p, input logic [7:0] eres, input logic [7:0] epo,
                        input logic ewr, input logic eerr, input int hold);
    int n;
    n = 0;
    req_op = op; req_a = a; req_b = b; p_in = p; req_valid = 1'b1; rsp_ready = 1'b0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_wait", (n < 20), 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = op ^ 4'h5; req_a = ~a; req_b = ~b; p_in = ~p;
    for (int cyc = 0; cyc < 2; cyc++) begin
      check("busy_req_ready", req_ready, 0);
      check("busy_rsp_valid", rsp_valid, 0);
      check("alu_select", flags, exp_sel(op));
      check("alu_dec_en", alu_dec_en, exp_dec(op, p));
      if (!eerr) begin
        check("alu_a", alu_a, a);
        check("alu_b_cin", {alu_b, alu_cin}, exp_bcin(op, a, b, p[0]));
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k <= hold; k++) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_result", rsp_result, eres);
      check("rsp_p", rsp_p, epo);
      check("rsp_wr", rsp_wr, ewr);
      check("rsp_err", rsp_err, eerr);
      check("resp_req_ready", req_ready, 0);
      check("resp_alu_select", flags, 0);
      req_valid = 1'b1;
      if (k == hold) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("release_rsp_valid", rsp_valid, 0);
    check("release_idle", req_ready, 1);
    check("idle_alu_select", flags, 0);
    req_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, p;
    logic [7:0] res, po;
    logic       wr, err;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [3:0] rop;
    logic [7:0] ra, rb, rp, mres, mpo;
    logic       mwr, merr;

    vecs[0]  = '{4'd0,  8'h50, 8'h50, 8'h20, 8'hA0, 8'hE0, 1'b1, 1'b0};
    vecs[1]  = '{4'd5,  8'h40, 8'h40, 8'h60, 8'h00, 8'h63, 1'b0, 1'b0};
    vecs[2]  = '{4'd10, 8'h01, 8'h00, 8'h21, 8'h80, 8'hA1, 1'b1, 1'b0};
    vecs[3]  = '{4'd8,  8'h01, 8'h00, 8'h20, 8'h00, 8'h23, 1'b1, 1'b0};
    vecs[4]  = '{4'd14, 8'h12, 8'h34, 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b1};
    vecs[5]  = '{4'd2,  8'hF0, 8'h3C, 8'h20, 8'h30, 8'h20, 1'b1, 1'b0};
    vecs[6]  = '{4'd6,  8'h0F, 8'hC0, 8'h20, 8'h00, 8'hE2, 1'b0, 1'b0};
    vecs[7]  = '{4'd1,  8'h00, 8'h01, 8'h21, 8'hFF, 8'hA0, 1'b1, 1'b0};
    vecs[8]  = '{4'd11, 8'hFF, 8'h00, 8'h21, 8'h00, 8'h23, 1'b1, 1'b0};
    vecs[9]  = '{4'd12, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hA0, 1'b1, 1'b0};
    vecs[10] = '{4'd7,  8'h81, 8'h00, 8'h20, 8'h02, 8'h21, 1'b1, 1'b0};
    vecs[11] = '{4'd9,  8'h80, 8'h00, 8'h21, 8'h01, 8'h21, 1'b1, 1'b0};
    vecs[12] = '{4'd4,  8'hFF, 8'hFF, 8'hA0, 8'h00, 8'h22, 1'b1, 1'b0};
    vecs[13] = '{4'd3,  8'h00, 8'h00, 8'h80, 8'h00, 8'h02, 1'b1, 1'b0};
    vecs[14] = '{4'd13, 8'hAA, 8'h55, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b1};
    vecs[15] = '{4'd15, 8'h01, 8'h02, 8'h01, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[16] = '{4'd0,  8'h01, 8'h02, 8'h28, 8'h03, 8'h28, 1'b1, 1'b0};
    vecs[17] = '{4'd2,  8'hFF, 8'h0F, 8'h28, 8'h0F, 8'h28, 1'b1, 1'b0};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'h0; req_a = 8'h00; req_b = 8'h00; p_in = 8'h00;

    // Reset state
    @(posedge clk); #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_p", rsp_p, 8'h24);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_wr_err", {rsp_wr, rsp_err}, 0);
    check("reset_alu_out", {alu_a, alu_b, flags, alu_cin, alu_dec_en}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_req_ready", req_ready, 1);

    // Directed table; vector 0 also backpressures for 5 cycles
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p,
             vecs[i].res, vecs[i].po, vecs[i].wr, vecs[i].err, (i == 0) ? 5 : (i % 3));
    end

    // Asynchronous reset while in SAMPLE
    run_op(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].p,
           vecs[0].res, vecs[0].po, vecs[0].wr, vecs[0].err, 0);
    req_op = 4'd0; req_a = 8'h7F; req_b = 8'h01; p_in = 8'h21; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_in_sample", flags, 5'b10000);
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_alu_out", {alu_a, alu_b, flags, alu_cin, alu_dec_en}, 0);
    check("async_rst_rsp_p", rsp_p, 8'h24);
    check("async_rst_rsp_result", {rsp_result, rsp_wr, rsp_err}, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_req_ready", req_ready, 1);
    check("after_rst_rsp_valid", rsp_valid, 0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 8'($urandom); rb = 8'($urandom); rp = 8'($urandom);
      model(rop, ra, rb, rp, mres, mpo, mwr, merr);
      run_op(rop, ra, rb, rp, mres, mpo, mwr, merr, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
